rd_fwft_stage: RTL and testbench

//  First-word-fall-through output stage for the async FIFO read side, downstream of the

---
 rtl/rd_fwft_stage.sv | 116 +++++++++++
 tb/tb_rd_fwft_stage.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/rd_fwft_stage.sv
// Purpose : first-word-fall-through output stage for the async FIFO read side.
// Latency : first word on DOUT C_RAM_LAT+1 cycles after RD_EMPTY falls, then 1 word/cycle.
// Backpr. : credit-limited issue; DOUT held stable while DOUT_VALID & !DOUT_READY.
//
// Ports:
//   RD_CLK / RD_RST_N       read-domain clock, synchronous active-low reset
//   RD_EMPTY / RD_EN        empty flag in, read request out (RAM read enable)
//   RAM_DOUT                RAM read data, valid C_RAM_LAT cycles after RD_EN
//   DOUT / DOUT_VALID / DOUT_READY   valid/ready output stream
//   OUT_LEVEL               words held in the output buffer (in-flight reads excluded)
//
// C_RAM_LAT is legal in the range 1..2.

module rd_fwft_stage #(
    parameter  int C_WIDTH   = 64,
    parameter  int C_RAM_LAT = 1,
    localparam int C_BUF     = C_RAM_LAT + 1,
    localparam int C_CNT_W   = $clog2(C_BUF + 1)
) (
    input  logic               RD_CLK,
    input  logic               RD_RST_N,
    input  logic               RD_EMPTY,
    output logic               RD_EN,
    input  logic [C_WIDTH-1:0] RAM_DOUT,
    output logic [C_WIDTH-1:0] DOUT,
    output logic               DOUT_VALID,
    input  logic               DOUT_READY,
    output logic [C_CNT_W-1:0] OUT_LEVEL
);

    localparam int IDX_W = (C_BUF > 2) ? 2 : 1;

    // One bit per outstanding RAM read; the last stage marks the cycle its data is on RAM_DOUT.
    logic [C_RAM_LAT-1:0] pipe_q, pipe_d;
    logic [C_WIDTH-1:0]   store_q [C_BUF];
    logic [C_WIDTH-1:0]   store_d [C_BUF];
    logic [IDX_W-1:0]     rd_idx_q, rd_idx_d;
    logic [IDX_W-1:0]     wr_idx_q, wr_idx_d;
    logic [C_CNT_W-1:0]   occ_q, occ_d;
    logic [C_CNT_W-1:0]   inflight;
    logic                 push;
    logic                 pop;
    logic                 rd_en;

    // Indices wrap at C_BUF, which is not a power of two when C_RAM_LAT=2.
    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
        if (idx == IDX_W'(C_BUF - 1)) begin
            return '0;
        end
        return idx + IDX_W'(1);
    endfunction

    always_comb begin
        inflight = '0;
        for (int i = 0; i < C_RAM_LAT; i++) begin
            inflight = inflight + C_CNT_W'(pipe_q[i]);
        end

        push = pipe_q[C_RAM_LAT-1];
        pop  = (occ_q != '0) && DOUT_READY;

        // Credit rule: buffered + in-flight never exceeds C_BUF. A same-cycle pop frees
        // a slot, so DOUT_READY feeds RD_EN combinationally to stream without bubbles.
        rd_en = RD_RST_N && !RD_EMPTY &&
                ((({1'b0, occ_q} + {1'b0, inflight}) < (C_CNT_W + 1)'(C_BUF)) || pop);

        pipe_d[0] = rd_en;
        for (int i = 1; i < C_RAM_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end

        store_d = store_q;
        if (push) begin
            store_d[wr_idx_q] = RAM_DOUT;
        end

        wr_idx_d = push ? idx_inc(wr_idx_q) : wr_idx_q;
        rd_idx_d = pop  ? idx_inc(rd_idx_q) : rd_idx_q;
        occ_d    = occ_q + C_CNT_W'(push) - C_CNT_W'(pop);
    end

    // Reset drops buffered and in-flight words; the FIFO pointers reset with us.
    always_ff @(posedge RD_CLK) begin
        if (!RD_RST_N) begin
            pipe_q   <= '0;
            rd_idx_q <= '0;
            wr_idx_q <= '0;
            occ_q    <= '0;
            for (int i = 0; i < C_BUF; i++) begin
                store_q[i] <= '0;
            end
        end else begin
            pipe_q   <= pipe_d;
            rd_idx_q <= rd_idx_d;
            wr_idx_q <= wr_idx_d;
            occ_q    <= occ_d;
            store_q  <= store_d;
        end
    end

    // DOUT comes only from registered state: no combinational path from RAM_DOUT.
    assign RD_EN      = rd_en;
    assign DOUT_VALID = (occ_q != '0);
    assign DOUT       = store_q[rd_idx_q];
    assign OUT_LEVEL  = occ_q;

    // Simulation-only invariants of the credit scheme.
    always_ff @(posedge RD_CLK) begin
        if (RD_RST_N) begin
            assert (int'(occ_q) + int'(inflight) <= C_BUF);
            assert (!(rd_en && RD_EMPTY));
            assert (!(push && !pop && (int'(occ_q) == C_BUF)));
        end
    end

endmodule

// File: tb/tb_rd_fwft_stage.sv
// Purpose : self-checking bench for rd_fwft_stage, C_RAM_LAT=1 and C_RAM_LAT=2 instances.
// Latency : reference model tracks words from FIFO through RAM delay into the output buffer.
// Backpr. : DOUT_READY driven directed or random; bench emulates FIFO + fixed-latency RAM.

module tb_rd_fwft_stage;

    logic        clk;
    logic        rst_n;
    logic        rd_empty   [2];
    logic        rd_en      [2];
    logic [63:0] ram_dout   [2];
    logic [63:0] dout       [2];
    logic        dout_valid [2];
    logic        dout_ready [2];
    logic [1:0]  out_level  [2];

    rd_fwft_stage #(.C_WIDTH(64), .C_RAM_LAT(1)) u_dut1 (
        .RD_CLK     (clk),
        .RD_RST_N   (rst_n),
        .RD_EMPTY   (rd_empty[0]),
        .RD_EN      (rd_en[0]),
        .RAM_DOUT   (ram_dout[0]),
        .DOUT       (dout[0]),
        .DOUT_VALID (dout_valid[0]),
        .DOUT_READY (dout_ready[0]),
        .OUT_LEVEL  (out_level[0])
    );

    rd_fwft_stage #(.C_WIDTH(64), .C_RAM_LAT(2)) u_dut2 (
        .RD_CLK     (clk),
        .RD_RST_N   (rst_n),
        .RD_EMPTY   (rd_empty[1]),
        .RD_EN      (rd_en[1]),
        .RAM_DOUT   (ram_dout[1]),
        .DOUT       (dout[1]),
        .DOUT_VALID (dout_valid[1]),
        .DOUT_READY (dout_ready[1]),
        .OUT_LEVEL  (out_level[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Active instance (0: latency 1, 1: latency 2) and its drive values.
    int   d     = 0;
    logic rst_v = 1'b0;
    logic rdy   = 1'b0;

    // Reference model: words waiting in the FIFO, reads in the RAM, words in the buffer.
    logic [63:0] src_q  [$];
    logic [63:0] fl_dat [$];
    int          fl_age [$];
    logic [63:0] buf_q  [$];
    logic [63:0] out_q  [$];
    logic [63:0] exp_w  [$];
    int          en_cnt = 0;

    // Values observed in the most recent step, for directed checks.
    logic        s_vld, s_en;
    logic [63:0] s_dat;
    logic [1:0]  s_lvl;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        int   lat, bsz;
        logic en_e, pop_e, en_a, pop_a;
        lat = d + 1;
        bsz = lat + 1;
        @(negedge clk);
        rst_n         = rst_v;
        dout_ready[d] = rdy;
        rd_empty[d]   = (src_q.size() == 0);
        #1;
        pop_e = (buf_q.size() != 0) && rdy;
        en_e  = rst_v && (src_q.size() != 0) &&
                (((buf_q.size() + fl_dat.size()) < bsz) || pop_e);
        s_vld = dout_valid[d];
        s_en  = rd_en[d];
        s_dat = dout[d];
        s_lvl = out_level[d];
        chk("dout_valid", 64'(s_vld), 64'(buf_q.size() != 0));
        chk("out_level", 64'(s_lvl), 64'(buf_q.size()));
        chk("rd_en", 64'(s_en), 64'(en_e));
        chk("en_while_empty", 64'(rd_en[d] & rd_empty[d]), 64'(0));
        if (buf_q.size() != 0) chk("dout", s_dat, buf_q[0]);
        en_a  = rd_en[d];
        pop_a = dout_valid[d] && rdy;
        if (en_a) en_cnt++;
        if (pop_a && rst_v) out_q.push_back(dout[d]);
        @(posedge clk);
        #1;
        if (!rst_v) begin
            buf_q.delete();
            fl_dat.delete();
            fl_age.delete();
        end else begin
            if (pop_e) void'(buf_q.pop_front());
            if (fl_age.size() > 0 && fl_age[0] == lat) begin
                buf_q.push_back(fl_dat.pop_front());
                void'(fl_age.pop_front());
            end
            foreach (fl_age[i]) fl_age[i] = fl_age[i] + 1;
            if (en_a && src_q.size() > 0) begin
                fl_dat.push_back(src_q.pop_front());
                fl_age.push_back(1);
            end
        end
        // RAM emulation: data valid exactly lat cycles after the read, garbage otherwise.
        if (fl_age.size() > 0 && fl_age[0] == lat) ram_dout[d] = fl_dat[0];
        else ram_dout[d] = {$urandom, $urandom};
        rd_empty[d] = (src_q.size() == 0);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rd_empty[i]   = 1'b1;
            dout_ready[i] = 1'b0;
            ram_dout[i]   = '0;
        end

        // Reset held with words available: nothing issued, outputs cleared.
        d = 0; rdy = 1'b1; rst_v = 1'b0;
        for (int i = 0; i < 8; i++) src_q.push_back(64'(i));
        repeat (3) begin
            step();
            chk("t1_rd_en", 64'(s_en), 64'(0));
            chk("t1_valid", 64'(s_vld), 64'(0));
            chk("t1_level", 64'(s_lvl), 64'(0));
            chk("t1_dout", s_dat, 64'(0));
        end

        // Latency 1 streaming: valid from cycle 2, 8 consecutive words, then idle.
        rst_v = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("t2_pre_valid", 64'(s_vld), 64'(0));
        end
        for (int i = 0; i < 8; i++) begin
            step();
            chk("t2_valid", 64'(s_vld), 64'(1));
            chk("t2_dout", s_dat, 64'(i));
        end
        step();
        chk("t2_end_valid", 64'(s_vld), 64'(0));

        // Backpressure: exactly C_BUF reads, buffer full, head held; then gap-free drain.
        rdy = 1'b0; en_cnt = 0;
        for (int i = 0; i < 5; i++) src_q.push_back(64'(i));
        repeat (6) step();
        chk("t3_pulses", 64'(en_cnt), 64'(2));
        chk("t3_level", 64'(s_lvl), 64'(2));
        chk("t3_hold", s_dat, 64'(0));
        rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_valid", 64'(s_vld), 64'(1));
            chk("t3_dout", s_dat, 64'(i));
        end
        step();
        chk("t3_end_valid", 64'(s_vld), 64'(0));

        // Single word with ready high: valid for exactly one cycle, level 1 then 0.
        src_q.push_back(64'hA5);
        step(); chk("t6_vld0", 64'(s_vld), 64'(0));
        step(); chk("t6_vld1", 64'(s_vld), 64'(0));
        step();
        chk("t6_vld2", 64'(s_vld), 64'(1));
        chk("t6_lvl2", 64'(s_lvl), 64'(1));
        chk("t6_dat2", s_dat, 64'hA5);
        step();
        chk("t6_vld3", 64'(s_vld), 64'(0));
        chk("t6_lvl3", 64'(s_lvl), 64'(0));

        // Latency 2, random source and random ready, 100 words in order.
        d = 1; out_q.delete(); exp_w.delete();
        begin
            int sent = 0;
            for (int c = 0; c < 3000 && out_q.size() < 100; c++) begin
                if (sent < 100 && $urandom_range(0, 2) != 0) begin
                    logic [63:0] w;
                    w = {$urandom, $urandom};
                    src_q.push_back(w);
                    exp_w.push_back(w);
                    sent++;
                end
                rdy = 1'($urandom_range(0, 1));
                step();
            end
        end
        chk("t4_count", 64'(out_q.size()), 64'(100));
        for (int i = 0; i < 100 && i < out_q.size(); i++) chk("t4_order", out_q[i], exp_w[i]);

        // Reset with reads in flight and a word buffered: all dropped, no stale push later.
        rdy = 1'b0; en_cnt = 0;
        for (int i = 0; i < 4; i++) src_q.push_back(64'h100 + 64'(i));
        repeat (3) step();
        chk("t5_issued", 64'(en_cnt), 64'(3));
        rst_v = 1'b0;
        src_q.delete();
        step();
        rst_v = 1'b1;
        step();
        chk("t5_valid", 64'(s_vld), 64'(0));
        chk("t5_level", 64'(s_lvl), 64'(0));
        repeat (4) begin
            step();
            chk("t5_no_stale", 64'(s_vld), 64'(0));
        end
        out_q.delete();
        rdy = 1'b1;
        for (int i = 0; i < 3; i++) src_q.push_back(64'h200 + 64'(i));
        repeat (8) step();
        chk("t5_post_count", 64'(out_q.size()), 64'(3));
        for (int i = 0; i < 3 && i < out_q.size(); i++) chk("t5_post_dat", out_q[i], 64'h200 + 64'(i));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
